inst_decode_pipe: RTL

- Registered, handshaked successor to the combinational opcode decoder.
- Accepts a byte stream from the fetch side, one byte per valid/ready handshake.
- Branch instructions (BEQ/BLE/BGE) are two bytes: an opcode byte followed by an 8-bit target byte. All other instructions are one byte.
- Emits one decoded instruction per output handshake, tagged with the address of its opcode byte, to the execute datapath.

---
 rtl/inst_pkg.sv | 46 ++++
 rtl/inst_classify.sv | 30 +++
 rtl/inst_decode_pipe.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/inst_pkg.sv
// Shared opcode constants, decoder state and decoded-instruction types
// for the instruction decode pipeline.
package inst_pkg;

  localparam int INST_W_DEF = 8;
  localparam int OPC_W_DEF  = 4;
  localparam int IMM_W_DEF  = INST_W_DEF - OPC_W_DEF;

  localparam logic [3:0] OP_NOOP   = 4'h0;
  localparam logic [3:0] OP_ADDI   = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_SUBI   = 4'h3;
  localparam logic [3:0] OP_AND    = 4'h4;
  localparam logic [3:0] OP_OR     = 4'h5;
  localparam logic [3:0] OP_XOR    = 4'h6;
  localparam logic [3:0] OP_NOT    = 4'h7;
  localparam logic [3:0] OP_SHIFTL = 4'h8;
  localparam logic [3:0] OP_SHIFTR = 4'h9;
  localparam logic [3:0] OP_LOAD   = 4'hA;
  localparam logic [3:0] OP_STORE  = 4'hB;
  localparam logic [3:0] OP_BEQ    = 4'hC;
  localparam logic [3:0] OP_BLE    = 4'hD;
  localparam logic [3:0] OP_BGE    = 4'hE;
  localparam logic [3:0] OP_ADD    = 4'hF;

  typedef enum logic {S_OP, S_IMM} state_t;

  typedef struct packed {
    logic branch;
    logic arith_imm;
    logic arith_mem;
    logic load;
    logic store;
    logic noop;
  } inst_class_t;

  typedef struct packed {
    logic [OPC_W_DEF-1:0]      opcode;
    logic [2**OPC_W_DEF-1:0]   onehot;
    logic [IMM_W_DEF-1:0]      imm;
    logic [INST_W_DEF-1:0]     br_target;
    logic [INST_W_DEF-1:0]     pc;
    inst_class_t               cls;
  } dec_inst_t;

endpackage

// File: rtl/inst_classify.sv
// Combinational opcode classifier: one-hot opcode vector plus class flags.
module inst_classify
  import inst_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0]    opcode,
  output logic [2**OPC_W-1:0] onehot,
  output inst_class_t         cls
);

  always_comb begin
    onehot         = '0;
    onehot[opcode] = 1'b1;
  end

  always_comb begin
    cls = '0;
    case (opcode)
      OP_BEQ, OP_BLE, OP_BGE:                      cls.branch    = 1'b1;
      OP_ADDI, OP_SUBI, OP_NOT, OP_SHIFTL,
      OP_SHIFTR:                                   cls.arith_imm = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:       cls.arith_mem = 1'b1;
      OP_LOAD:                                     cls.load      = 1'b1;
      OP_STORE:                                    cls.store     = 1'b1;
      default:                                     cls.noop      = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_decode_pipe.sv
// Registered valid/ready instruction decoder with two-byte branch assembly.
// Optional PERF_CNT_EN adds saturating instruction/branch counters.
module inst_decode_pipe
  import inst_pkg::*;
#(
  parameter int INST_W = 8,
  parameter int OPC_W  = 4,
  parameter int IMM_W  = INST_W - OPC_W,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INST_W-1:0]    in_byte,
  input  logic                 flush,
  input  logic [INST_W-1:0]    flush_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INST_W-1:0]    out_pc,
  output logic [OPC_W-1:0]     out_opcode,
  output logic [2**OPC_W-1:0]  out_onehot,
  output logic [IMM_W-1:0]     out_imm,
  output logic [INST_W-1:0]    out_br_target,
  output logic                 out_branch,
  output logic                 out_arith_imm,
  output logic                 out_arith_mem,
  output logic                 out_load,
  output logic                 out_store,
  output logic                 out_noop
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     perf_insts,
  output logic [CNT_W-1:0]     perf_branches
`endif
);

  if (IMM_W != INST_W - OPC_W || CNT_W < 1) begin : g_param_check
    $error("inst_decode_pipe: inconsistent parameters");
  end

  state_t              state;
  logic [INST_W-1:0]   pc;
  logic [OPC_W-1:0]    pend_opc;
  logic [IMM_W-1:0]    pend_imm;
  logic [INST_W-1:0]   pend_pc;

  logic [OPC_W-1:0]    in_opc;
  logic [IMM_W-1:0]    in_imm;
  logic [OPC_W-1:0]    dec_opc;
  logic [2**OPC_W-1:0] dec_onehot;
  inst_class_t         dec_cls;
  logic                accept;

  assign in_opc   = in_byte[INST_W-1 -: OPC_W];
  assign in_imm   = in_byte[IMM_W-1:0];
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // In S_IMM the byte on the bus is a target, so classify the held opcode.
  assign dec_opc = (state == S_IMM) ? pend_opc : in_opc;

  inst_classify #(.OPC_W(OPC_W)) u_classify (
    .opcode (dec_opc),
    .onehot (dec_onehot),
    .cls    (dec_cls)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_OP;
      pc            <= '0;
      pend_opc      <= '0;
      pend_imm      <= '0;
      pend_pc       <= '0;
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_opcode    <= '0;
      out_onehot    <= '0;
      out_imm       <= '0;
      out_br_target <= '0;
      out_branch    <= 1'b0;
      out_arith_imm <= 1'b0;
      out_arith_mem <= 1'b0;
      out_load      <= 1'b0;
      out_store     <= 1'b0;
      out_noop      <= 1'b0;
    end else if (flush) begin
      state     <= S_OP;
      pc        <= flush_pc;
      pend_opc  <= '0;
      pend_imm  <= '0;
      pend_pc   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        pc <= pc + INST_W'(1);
        if (state == S_OP && dec_cls.branch) begin
          pend_opc <= in_opc;
          pend_imm <= in_imm;
          pend_pc  <= pc;
          state    <= S_IMM;
        end else begin
          out_valid     <= 1'b1;
          out_onehot    <= dec_onehot;
          out_branch    <= dec_cls.branch;
          out_arith_imm <= dec_cls.arith_imm;
          out_arith_mem <= dec_cls.arith_mem;
          out_load      <= dec_cls.load;
          out_store     <= dec_cls.store;
          out_noop      <= dec_cls.noop;
          if (state == S_IMM) begin
            out_opcode    <= pend_opc;
            out_imm       <= pend_imm;
            out_pc        <= pend_pc;
            out_br_target <= in_byte;
            state         <= S_OP;
          end else begin
            out_opcode    <= in_opc;
            out_imm       <= in_imm;
            out_pc        <= pc;
            out_br_target <= '0;
          end
        end
      end
    end
  end

`ifdef PERF_CNT_EN
  // Counted on the output handshake itself, so flush never rewinds them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_insts    <= '0;
      perf_branches <= '0;
    end else if (out_valid && out_ready) begin
      if (perf_insts != '1) begin
        perf_insts <= perf_insts + CNT_W'(1);
      end
      if (out_branch && perf_branches != '1) begin
        perf_branches <= perf_branches + CNT_W'(1);
      end
    end
  end
`endif

endmodule
